// File: rtl/conv_pass_scheduler.sv
// conv_pass_scheduler: paces 3x3 windows into the conv engine over NPHASE channel-group passes
module conv_pass_scheduler #(
  parameter int IMG_W    = 28,
  parameter int IMG_H    = 28,
  parameter int NPHASE   = 4,
  parameter int PIPE_LAT = 3,
  parameter int ADDRW    = 10
)(
  input  logic             iClk,
  input  logic             iRsn,
  input  logic             iStart,
  input  logic             iAbort,
  input  logic             iWinValid,
  output logic             oWinReady,
  output logic             oConvInValid,
  output logic             oMapDone,
  output logic [1:0]       oPhase,
  output logic             oRewind,
  output logic             oOutWrEn,
  output logic [ADDRW-1:0] oOutAddr,
  output logic [3:0]       oOutChBase,
  output logic             oBusy,
  output logic             oLayerDone
);
  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);
  localparam int DW = $clog2(PIPE_LAT + 1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, MAPDONE} state_t;
  state_t state;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [DW-1:0] drain;
  logic [1:0] phase;
  logic [PIPE_LAT-1:0] pv;
  logic [ADDRW-1:0] pa [PIPE_LAT];
  logic accept, col_end, row_end, last_phase;
  logic [ADDRW-1:0] addr;
  always_comb begin
    col_end    = col == CW'(IMG_W - 3);
    row_end    = row == RW'(IMG_H - 3);
    last_phase = phase == 2'(NPHASE - 1);
    accept     = iWinValid && state == RUN;
    addr       = ADDRW'(row) * ADDRW'(IMG_W - 2) + ADDRW'(col);
  end
  // abort suppresses the map-done family even in the MAPDONE cycle itself
  assign oWinReady    = state == RUN;
  assign oConvInValid = accept;
  assign oMapDone     = state == MAPDONE && !iAbort;
  assign oLayerDone   = oMapDone && last_phase;
  assign oRewind      = oMapDone && !last_phase;
  assign oPhase       = phase;
  assign oOutChBase   = {phase, 2'b00};
  assign oBusy        = state != IDLE;
  assign oOutWrEn     = pv[PIPE_LAT-1];
  assign oOutAddr     = pa[PIPE_LAT-1];
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      state <= IDLE;
      phase <= '0;
      row   <= '0;
      col   <= '0;
      drain <= '0;
      pv    <= '0;
      pa    <= '{default: '0};
    end else if (iAbort) begin
      state <= IDLE;
      phase <= '0;
      row   <= '0;
      col   <= '0;
      drain <= '0;
      pv    <= '0;
      pa    <= '{default: '0};
    end else begin
      pv[0] <= accept;
      pa[0] <= addr;
      for (int i = 1; i < PIPE_LAT; i++) begin
        pv[i] <= pv[i-1];
        pa[i] <= pa[i-1];
      end
      case (state)
        IDLE: if (iStart) begin
          state <= RUN;
          phase <= '0;
          row   <= '0;
          col   <= '0;
        end
        RUN: if (accept) begin
          if (col_end && row_end) begin
            state <= DRAIN;
            drain <= DW'(PIPE_LAT);
          end else begin
            col <= col_end ? '0 : col + 1'b1;
            row <= col_end ? row + 1'b1 : row;
          end
        end
        DRAIN: begin
          drain <= drain - 1'b1;
          if (drain == DW'(1)) state <= MAPDONE;
        end
        MAPDONE: begin
          row   <= '0;
          col   <= '0;
          phase <= last_phase ? '0 : phase + 1'b1;
          state <= last_phase ? IDLE : RUN;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_conv_pass_scheduler.sv
// tb_conv_pass_scheduler: vector table, directed layer scenarios and random traffic against a cycle-schedule model
module tb_conv_pass_scheduler;
  localparam int W = 5, H = 5, NP = 4, PL = 3, AW = 10, NWIN = (W-2)*(H-2);
  logic iClk = 0, iRsn = 0, iStart = 0, iAbort = 0, iWinValid = 0;
  logic oWinReady, oConvInValid, oMapDone, oRewind, oOutWrEn, oBusy, oLayerDone;
  logic [1:0] oPhase;
  logic [AW-1:0] oOutAddr;
  logic [3:0] oOutChBase;
  always #5 iClk = ~iClk;
  conv_pass_scheduler #(.IMG_W(W), .IMG_H(H), .NPHASE(NP), .PIPE_LAT(PL), .ADDRW(AW)) dut (
    .iClk(iClk), .iRsn(iRsn), .iStart(iStart), .iAbort(iAbort), .iWinValid(iWinValid),
    .oWinReady(oWinReady), .oConvInValid(oConvInValid), .oMapDone(oMapDone), .oPhase(oPhase),
    .oRewind(oRewind), .oOutWrEn(oOutWrEn), .oOutAddr(oOutAddr), .oOutChBase(oOutChBase),
    .oBusy(oBusy), .oLayerDone(oLayerDone)
  );
  typedef struct {
    bit s, a, w, e_rdy, e_civ, e_wr, e_busy;
    int e_addr;
  } vec_t;
  vec_t tbl [10];
  int n_cmp = 0, n_err = 0, t = 0;
  // model: a pass is "live" until NWIN windows are taken; results due PL cycles after each accept
  bit active = 0;
  int phase = 0, nacc = 0, md_t = -1;
  int wr_q [int];
  int n_md, n_rw, n_ld, n_acc, n_wr, first_acc, ld_t;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0d got=%0h exp=%0h", nm, t, act, exp);
    end
  endtask
  task automatic model_reset();
    active = 0; phase = 0; nacc = 0; md_t = -1;
    wr_q.delete();
  endtask
  task automatic step(input bit s, input bit a, input bit w);
    bit rdy, md, was;
    iStart = s; iAbort = a; iWinValid = w;
    #1;
    rdy = active && nacc < NWIN;
    md  = active && t == md_t && !a;
    chk("ready", oWinReady, rdy);
    chk("in_valid", oConvInValid, w && rdy);
    chk("busy", oBusy, active);
    chk("phase", oPhase, phase);
    chk("ch_base", oOutChBase, phase*4);
    chk("map_done", oMapDone, md);
    chk("layer_done", oLayerDone, md && phase == NP-1);
    chk("rewind", oRewind, md && phase != NP-1);
    chk("wr_en", oOutWrEn, wr_q.exists(t) != 0);
    if (wr_q.exists(t)) begin
      chk("addr", oOutAddr, wr_q[t]);
      n_wr++;
      wr_q.delete(t);
    end
    if (md) n_md++;
    if (md && phase == NP-1) begin n_ld++; ld_t = t; end
    if (md && phase != NP-1) n_rw++;
    if (w && rdy) begin n_acc++; if (first_acc < 0) first_acc = t; end
    if (a) model_reset();
    else begin
      was = active;
      if (w && rdy) begin
        wr_q[t+PL] = nacc;
        nacc++;
        if (nacc == NWIN) md_t = t + PL + 1;
      end
      if (md) begin
        nacc = 0; md_t = -1;
        if (phase == NP-1) begin active = 0; phase = 0; end
        else phase++;
      end
      if (!was && s) begin active = 1; phase = 0; nacc = 0; end
    end
    @(posedge iClk);
    t++;
    @(negedge iClk);
  endtask
  task automatic run_layer(input bit toggle);
    n_md = 0; n_rw = 0; n_ld = 0; n_acc = 0; n_wr = 0; first_acc = -1; ld_t = 0;
    step(1, 0, 1);
    for (int k = 0; k < 300 && n_ld == 0; k++) step(0, 0, toggle ? (k % 2 == 0) : 1'b1);
    chk("layer_seen", n_ld, 1);
    chk("map_done_cnt", n_md, NP);
    chk("rewind_cnt", n_rw, NP-1);
    chk("accept_cnt", n_acc, NP*NWIN);
    chk("write_cnt", n_wr, NP*NWIN);
    if (!toggle) chk("layer_cycles", ld_t - first_acc + 1, 52);
  endtask
  initial begin
    tbl[0] = '{0,0,1, 0,0,0,0, 0};
    tbl[1] = '{1,0,1, 0,0,0,0, 0};
    tbl[2] = '{0,0,1, 1,1,0,1, 0};
    tbl[3] = '{0,0,0, 1,0,0,1, 0};
    tbl[4] = '{0,0,1, 1,1,0,1, 0};
    tbl[5] = '{1,0,1, 1,1,1,1, 0};
    tbl[6] = '{0,0,0, 1,0,0,1, 0};
    tbl[7] = '{0,0,1, 1,1,1,1, 1};
    tbl[8] = '{0,1,1, 1,1,1,1, 2};
    tbl[9] = '{0,0,1, 0,0,0,0, 0};
    repeat (2) @(negedge iClk);
    iRsn = 1;
    foreach (tbl[i]) begin
      iStart = tbl[i].s; iAbort = tbl[i].a; iWinValid = tbl[i].w;
      #1;
      chk("v_ready", oWinReady, tbl[i].e_rdy);
      chk("v_in_valid", oConvInValid, tbl[i].e_civ);
      chk("v_wr_en", oOutWrEn, tbl[i].e_wr);
      chk("v_busy", oBusy, tbl[i].e_busy);
      if (tbl[i].e_wr || !tbl[i].e_busy) chk("v_addr", oOutAddr, tbl[i].e_addr);
      step(tbl[i].s, tbl[i].a, tbl[i].w);
    end
    run_layer(0);
    repeat (3) step(0, 0, 1);
    run_layer(1);
    // abort while draining phase 2
    step(1, 0, 1);
    for (int k = 0; k < 200 && !(phase == 2 && nacc == NWIN); k++) step(0, 0, 1);
    chk("drain2_phase", oPhase, 2);
    chk("drain2_ready", oWinReady, 0);
    step(0, 1, 1);
    chk("abort_busy", oBusy, 0);
    chk("abort_phase", oPhase, 0);
    repeat (8) step(0, 0, 1);
    run_layer(0);
    // asynchronous reset in the middle of phase 1
    step(1, 0, 1);
    for (int k = 0; k < 200 && !(phase == 1 && nacc == 4); k++) step(0, 0, 1);
    chk("pre_rst_phase", oPhase, 1);
    #2 iRsn = 0;
    #1;
    chk("rst_ready", oWinReady, 0);
    chk("rst_in_valid", oConvInValid, 0);
    chk("rst_map_done", oMapDone, 0);
    chk("rst_rewind", oRewind, 0);
    chk("rst_wr_en", oOutWrEn, 0);
    chk("rst_addr", oOutAddr, 0);
    chk("rst_ch_base", oOutChBase, 0);
    chk("rst_busy", oBusy, 0);
    chk("rst_layer_done", oLayerDone, 0);
    chk("rst_phase", oPhase, 0);
    model_reset();
    @(negedge iClk);
    iRsn = 1;
    repeat (5) step(0, 0, 1);
    run_layer(1);
    repeat (3000) step($urandom_range(0, 19) == 0, $urandom_range(0, 149) == 0, $urandom_range(0, 9) < 7);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
